// File: rtl/mult_pkg.sv
// Shared widths, state encoding and capture payload for the multiply writeback sequencer.
package mult_pkg;

  localparam int unsigned RW   = 4;
  localparam int unsigned DW   = 32;
  localparam int unsigned RESW = 2 * DW;

  typedef enum logic [1:0] {
    MWB_IDLE  = 2'b00,
    MWB_WR_LO = 2'b01,
    MWB_WR_HI = 2'b10
  } mwb_state_e;

  // Everything latched from the EX stage when a multiply completes.
  typedef struct packed {
    logic [RESW-1:0] res;
    logic [RW-1:0]   rd_lo;
    logic [RW-1:0]   rd_hi;
    logic            l;
    logic            s;
  } mwb_cap_t;

endpackage

// File: rtl/mult_flags.sv
// N/Z flag generation for 32-bit and 64-bit multiply results.
module mult_flags
  import mult_pkg::*;
(
  input  logic [RESW-1:0] res,
  input  logic            l,
  output logic            n_c,
  output logic            z_c
);

  assign n_c = l ? res[RESW-1] : res[DW-1];
  assign z_c = l ? (res == '0) : (res[DW-1:0] == '0);

endmodule

// File: rtl/mult_wb.sv
// Multiply writeback sequencer: captures the final sum and drains RdLo then RdHi
// through the single register-file write port, with N/Z flag update and upstream stall.
module mult_wb
  import mult_pkg::*;
(
  input  logic            nGCLK,
  input  logic            nThisReset,
  input  logic            nWAIT,
  input  logic            flush,
  input  logic            mul_done,
  input  logic [RESW-1:0] sum,
  input  logic            l,
  input  logic            s,
  input  logic [RW-1:0]   rd_lo,
  input  logic [RW-1:0]   rd_hi,
  output logic            wr_en,
  output logic [RW-1:0]   wr_addr,
  output logic [DW-1:0]   wr_data,
  output logic            flag_we,
  output logic            n_flag,
  output logic            z_flag,
  output logic            wb_hold
);

  mwb_state_e state_q, state_d;
  mwb_cap_t   cap_q, cap_d;
  logic       capture_c;
  logic       final_c;
  logic       active_c;
  logic       go_c;
  logic       n_c, z_c;

  mult_flags u_flags (
    .res (cap_q.res),
    .l   (cap_q.l),
    .n_c (n_c),
    .z_c (z_c)
  );

  always_ff @(posedge nGCLK or negedge nThisReset) begin
    if (!nThisReset) begin
      state_q <= MWB_IDLE;
      cap_q   <= '0;
    end else begin
      state_q <= state_d;
      cap_q   <= cap_d;
    end
  end

  // Next state, capture and write-port outputs.
  always_comb begin
    state_d   = state_q;
    cap_d     = cap_q;
    capture_c = 1'b0;
    final_c   = 1'b0;
    wr_addr   = '0;
    wr_data   = '0;
    wb_hold   = 1'b0;

    case (state_q)
      MWB_IDLE: begin
        capture_c = mul_done;
        wb_hold   = mul_done & l;
        state_d   = MWB_IDLE;
      end
      MWB_WR_LO: begin
        wr_addr   = cap_q.rd_lo;
        wr_data   = cap_q.res[DW-1:0];
        wb_hold   = cap_q.l;
        final_c   = ~cap_q.l;
        capture_c = mul_done & ~cap_q.l;
        state_d   = cap_q.l ? MWB_WR_HI : MWB_IDLE;
      end
      MWB_WR_HI: begin
        wr_addr = cap_q.rd_hi;
        wr_data = cap_q.res[RESW-1:DW];
        wb_hold = 1'b1;
        final_c = 1'b1;
        state_d = MWB_IDLE;
      end
      default: state_d = MWB_IDLE;
    endcase

    // A stalled edge holds everything; flush wins over capture.
    if (!nWAIT) begin
      state_d = state_q;
    end else if (flush) begin
      state_d = MWB_IDLE;
    end else if (capture_c) begin
      state_d     = MWB_WR_LO;
      cap_d.res   = sum;
      cap_d.rd_lo = rd_lo;
      cap_d.rd_hi = rd_hi;
      cap_d.l     = l;
      cap_d.s     = s;
    end
  end

  assign active_c = (state_q != MWB_IDLE);
  assign go_c     = nWAIT & ~flush;
  assign wr_en    = active_c & go_c;
  assign flag_we  = cap_q.s & final_c & go_c;
  assign n_flag   = active_c & n_c;
  assign z_flag   = active_c & z_c;

endmodule
